wb_sram_initiator: RTL and testbench

- Wishbone classic single-beat master; the initiator end of the Wishbone slave port that fronts the sky130 SRAM macros in the user project.
- Accepts one command at a time on a valid/ready command port, runs one wbm_cyc_o/wbm_stb_o cycle, and returns a response on a valid/ready response port.
- A per-cycle timeout guards against a non-acking slave. Used by on-chip test engines and logic-analyzer-driven SRAM exercisers.

---
 rtl/wb_init_pkg.sv | 14 +
 rtl/wb_init_timeout.sv | 32 +++
 rtl/wb_sram_initiator.sv | 122 ++++++++++++
 tb/tb_wb_sram_initiator.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_init_pkg.sv
// Shared types and bus geometry for the Wishbone initiator family.
package wb_init_pkg;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_SELW = 4;
  localparam int unsigned WB_AW   = 32;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } wb_state_e;

endpackage

// File: rtl/wb_init_timeout.sv
// Loadable up-counter with clear and enable; flags when the count equals a limit.
module wb_init_timeout #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count_q;

  // Clear has priority over load, load over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en) begin
      count_q <= count_q + W'(1);
    end
  end

  assign expired = (count_q == limit);

endmodule

// File: rtl/wb_sram_initiator.sv
// Wishbone classic single-beat master: one command in, one bus cycle, one response out.
module wb_sram_initiator
  import wb_init_pkg::*;
#(
  parameter int unsigned AW      = 9,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_we_i,
  input  logic [AW-1:0]      cmd_adr_i,
  input  logic [WB_DW-1:0]   cmd_dat_i,
  input  logic [WB_SELW-1:0] cmd_sel_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [WB_DW-1:0]   rsp_dat_o,
  output logic               rsp_err_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_SELW-1:0] wbm_sel_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  output logic               busy_o,
  output logic [CNT_W-1:0]   txn_cnt_o
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned    TO_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT - 1);
  localparam bit             TO_EN    = (TIMEOUT != 0);

  wb_state_e state_q;
  logic      accept;
  logic      to_en;
  logic      to_expired;

  assign accept = (state_q == StIdle) && cmd_valid_i && cmd_ready_o;
  assign to_en  = (state_q == StBus) && !wbm_ack_i;

  wb_init_timeout #(
    .W (TO_W)
  ) u_timeout (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .clr      (accept),
    .load     (1'b0),
    .load_val ({TO_W{1'b0}}),
    .en       (to_en),
    .limit    (TO_LIMIT),
    .expired  (to_expired)
  );

  // Control FSM; every output is a register updated here.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= StIdle;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      busy_o      <= 1'b0;
      txn_cnt_o   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            wbm_we_o    <= cmd_we_i;
            wbm_adr_o   <= {{(WB_AW-AW){1'b0}}, cmd_adr_i};
            wbm_dat_o   <= cmd_dat_i;
            wbm_sel_o   <= cmd_sel_i;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state_q     <= StBus;
          end
        end
        StBus: begin
          // Ack takes precedence over a timeout firing in the same cycle.
          if (wbm_ack_i) begin
            rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            txn_cnt_o   <= txn_cnt_o + CNT_W'(1);
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state_q     <= StResp;
          end else if (TO_EN && to_expired) begin
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_initiator.sv
// Directed bench for wb_sram_initiator with a small Wishbone slave model.
module tb_wb_sram_initiator;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [8:0]  cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc;
  logic        wbm_stb;
  logic        wbm_we;
  logic [31:0] wbm_adr;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack;
  logic        busy;
  logic [3:0]  txn_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int exp_cnt  = 0;

  // Slave model state
  logic [31:0] mem [0:511];
  int          ack_delay = 0;
  int          stb_cnt   = 0;
  logic        slv_ack   = 1'b0;
  logic        force_ack = 1'b0;

  wb_sram_initiator #(
    .AW      (9),
    .TIMEOUT (16),
    .CNT_W   (4)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_stb_o   (wbm_stb),
    .wbm_we_o    (wbm_we),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack),
    .busy_o      (busy),
    .txn_cnt_o   (txn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign wbm_ack   = slv_ack | force_ack;
  assign wbm_dat_i = mem[wbm_adr[8:0]];

  // Ack decision made mid-cycle: ack in the (ack_delay+1)-th cycle of stb.
  always @(negedge clk) begin
    if (wbm_cyc && wbm_stb) begin
      slv_ack = (stb_cnt == ack_delay);
      stb_cnt = stb_cnt + 1;
    end else begin
      slv_ack = 1'b0;
      stb_cnt = 0;
    end
  end

  // Byte-lane write into the slave memory on an acked write.
  always @(posedge clk) begin
    if (slv_ack && wbm_cyc && wbm_stb && wbm_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbm_sel[b]) mem[wbm_adr[8:0]][8*b +: 8] = wbm_dat_o[8*b +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until the accepting edge.
  task automatic issue(input logic we, input logic [8:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int delay);
    int n;
    ack_delay = delay;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    check_eq("issue_ready", {31'b0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Count stb cycles until the response appears, then check it.
  task automatic wait_rsp(input string tag, input int exp_stb, input logic [31:0] exp_dat,
                          input logic exp_err, input logic [8:0] adr, input logic we);
    int n;
    int stb_n;
    n = 0;
    stb_n = 0;
    while (!rsp_valid && n < 40) begin
      if (wbm_cyc && wbm_stb) begin
        stb_n++;
        if (stb_n == 1) begin
          check_eq({tag, "_adr"}, wbm_adr, {23'b0, adr});
          check_eq({tag, "_we"}, {31'b0, wbm_we}, {31'b0, we});
        end
      end
      step();
      n++;
    end
    check_eq({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    check_eq({tag, "_stb_cycles"}, stb_n, exp_stb);
    check_eq({tag, "_dat"}, rsp_dat, exp_dat);
    check_eq({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    check_eq({tag, "_cyc_low"}, {31'b0, wbm_cyc}, 32'd0);
    check_eq({tag, "_cnt"}, {28'b0, txn_cnt}, exp_cnt);
  endtask

  task automatic take_rsp(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, {31'b0, rsp_valid}, 32'd0);
    check_eq({tag, "_ready_back"}, {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_dat;
    for (int i = 0; i < 512; i++) mem[i] = 32'hA500_0000 | i;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;

    // Reset state
    step();
    step();
    check_eq("rst_cyc", {31'b0, wbm_cyc}, 32'd0);
    check_eq("rst_adr", wbm_adr, 32'd0);
    check_eq("rst_cnt", {28'b0, txn_cnt}, 32'd0);
    check_eq("rst_valid", {31'b0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("rel_ready", {31'b0, cmd_ready}, 32'd1);
    check_eq("rel_busy", {31'b0, busy}, 32'd0);

    // Write then read back
    issue(1'b1, 9'h005, 32'hDEAD_BEEF, 4'hF, 0);
    exp_cnt = 1;
    wait_rsp("wr", 1, 32'h0, 1'b0, 9'h005, 1'b1);
    take_rsp("wr");
    issue(1'b0, 9'h005, 32'h0, 4'hF, 0);
    exp_cnt = 2;
    wait_rsp("rd", 1, 32'hDEAD_BEEF, 1'b0, 9'h005, 1'b0);
    take_rsp("rd");

    // Three wait states
    issue(1'b0, 9'h005, 32'h0, 4'hF, 3);
    exp_cnt = 3;
    wait_rsp("ws", 4, 32'hDEAD_BEEF, 1'b0, 9'h005, 1'b0);
    take_rsp("ws");

    // Timeout with no ack, then ack in the very cycle the timeout would fire
    issue(1'b0, 9'h007, 32'h0, 4'hF, 99);
    wait_rsp("to", 16, 32'h0, 1'b1, 9'h007, 1'b0);
    take_rsp("to");
    issue(1'b0, 9'h007, 32'h0, 4'hF, 15);
    exp_cnt = 4;
    wait_rsp("to_ack", 16, 32'hA500_0007, 1'b0, 9'h007, 1'b0);
    take_rsp("to_ack");

    // Response backpressure with a competing command
    issue(1'b0, 9'h009, 32'h0, 4'hF, 0);
    exp_cnt = 5;
    wait_rsp("bp", 1, 32'hA500_0009, 1'b0, 9'h009, 1'b0);
    held_dat  = rsp_dat;
    cmd_we    = 1'b1;
    cmd_adr   = 9'h011;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check_eq("bp_dat", rsp_dat, held_dat);
      check_eq("bp_ready", {31'b0, cmd_ready}, 32'd0);
      check_eq("bp_stb", {31'b0, wbm_stb}, 32'd0);
    end
    check_eq("bp_err", {31'b0, rsp_err}, 32'd0);
    cmd_valid = 1'b0;
    take_rsp("bp");
    check_eq("bp_cnt", {28'b0, txn_cnt}, exp_cnt);

    // Reset while the bus cycle is in flight
    issue(1'b0, 9'h003, 32'h1234_5678, 4'h3, 99);
    step();
    step();
    step();
    check_eq("mid_stb_pre", {31'b0, wbm_stb}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_stb_drop", {31'b0, wbm_stb}, 32'd0);
    check_eq("mid_cyc_drop", {31'b0, wbm_cyc}, 32'd0);
    check_eq("mid_dat", wbm_dat_o, 32'd0);
    check_eq("mid_sel", {28'b0, wbm_sel}, 32'd0);
    check_eq("mid_cnt", {28'b0, txn_cnt}, 32'd0);
    check_eq("mid_busy", {31'b0, busy}, 32'd0);
    check_eq("mid_rsp_dat", rsp_dat, 32'd0);
    exp_cnt = 0;
    step();
    rst_n = 1'b1;
    step();
    check_eq("mid_rel_ready", {31'b0, cmd_ready}, 32'd1);

    // Stray ack while idle
    force_ack = 1'b1;
    step();
    step();
    force_ack = 1'b0;
    step();
    check_eq("stray_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("stray_cnt", {28'b0, txn_cnt}, 32'd0);
    check_eq("stray_busy", {31'b0, busy}, 32'd0);

    // Transaction counter wrap (4-bit counter)
    for (int i = 0; i < 17; i++) begin
      issue(1'b0, 9'(32 + i), 32'h0, 4'hF, 0);
      exp_cnt = (exp_cnt + 1) % 16;
      wait_rsp("wrap", 1, 32'hA500_0000 | (32 + i), 1'b0, 9'(32 + i), 1'b0);
      take_rsp("wrap");
    end
    check_eq("wrap_final", {28'b0, txn_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
